mat_feed_ctrl: RTL and testbench
================================

Name: mat_feed_ctrl

Overview:
- Initiator/writer side of the matrix pipeline's load-and-readback interface.
- Accepts a valid/ready stream of operand pairs and drives the 1-based (index, a, b) load sequence into the pipeline.
- Signals end-of-load, waits for the pipeline's completion flag, then sweeps the result index and returns results as a valid/ready stream.

Parameters:
- DATA_W, 32, operand/result width (signed)
- NUM_ELEM, 512, operand pairs per load
- NUM_RES, 32, result words read back
- RD_LAT, 1, cycles from mat_index change to valid mat_sumout
- FIFO_DEPTH, 4, result buffer entries (power of 2, >= RD_LAT+1)
- TIMEOUT, 65535, WAIT-state watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a load/readback job (sampled in IDLE only)
- in_valid  in  1  operand pair valid
- in_ready  out  1  operand pair accepted when in_valid & in_ready
- in_a  in  DATA_W  operand a
- in_b  in  DATA_W  operand b
- mat_a  out  DATA_W  operand a to pipeline
- mat_b  out  DATA_W  operand b to pipeline
- mat_index  out  32  load index (1..NUM_ELEM), end marker, or result index
- mat_done  in  1  pipeline completion flag (level)
- mat_sumout  in  DATA_W  pipeline result for current index
- res_valid  out  1  result available
- res_ready  in  1  result consumed when res_valid & res_ready
- res_data  out  DATA_W  result word
- res_idx  out  8  result index 0..NUM_RES-1
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when the last result is popped
- err  out  1  sticky watchdog error (0 without the optional feature)

Behaviour:
- Reset: all outputs 0, state IDLE, counters and FIFO cleared. Reset mid-job aborts immediately with no resume; in-flight operands and results are discarded.
- IDLE: mat_index=0, in_ready=0. If start=1, go to LOAD and set cnt=0. err is cleared on start.
- LOAD: in_ready=1.
  - On each accepted beat, register mat_a=in_a, mat_b=in_b, mat_index=cnt+1 on the next edge; cnt++.
  - Each beat produces a distinct index because the pipeline detects new data by index change. Back-to-back beats give one beat per cycle; in_valid gaps hold the previous outputs.
  - After beat NUM_ELEM is accepted, in_ready drops the same cycle. The next cycle drives mat_index=NUM_ELEM+1 (end marker), and the state moves to WAIT.
- WAIT: hold the end marker and in_ready=0. When mat_done=1, set ridx=0 and go to READ.
- READ:
  - Issue one result index per cycle when in-flight + occupancy < FIFO_DEPTH; mat_index=ridx, ridx++.
  - Capture mat_sumout RD_LAT cycles after issue into the FIFO, tagged with its ridx.
  - Go to DRAIN after NUM_RES indices are issued.
- DRAIN: wait until all captures are done and the FIFO is empty. Pulse done on the cycle the final pop occurs, then go to IDLE.
- FIFO: first-word-fall-through; res_valid = !empty. A push and a pop in the same cycle are allowed when full. No overflow is possible by construction; the bench asserts against overflow.
- start while busy is ignored.
- If mat_done drops during READ, the sweep continues and the values are taken as presented.
- Width rules: index arithmetic is unsigned 32-bit; data passes through unmodified and signed.
- Latency: operand accept to mat_* update is 1 cycle; end marker appears 1 cycle after the last accept; first res_valid is RD_LAT+2 cycles after READ entry.

Optional Feature:
- Macro MAT_FEED_TIMEOUT_EN.
- Defined: a WAIT-state counter runs. If mat_done is not seen within TIMEOUT cycles, set err=1 (sticky until the next start or reset), return to IDLE, and do not pulse done.
- Not defined: WAIT waits forever and err is tied to 0.

Decomposition:
- Shared package mat_pkg:
  - state enum {IDLE, LOAD, WAIT, READ, DRAIN}
  - DATA_W default
  - NUM_ELEM and NUM_RES constants
  - index-width constant
  - END_MARKER = NUM_ELEM+1
- Sub-module mat_res_fifo: synchronous FWFT FIFO carrying {res_idx, res_data}, with asynchronous active-high reset and full/empty/count outputs.

Test Plan:
- Normal job: start; stream 512 pairs (a=i, b=-i) with in_valid always high -> mat_index steps 1..512 on consecutive cycles, 513 on the next cycle; in_ready=0 after beat 512.
- Bubbles: in_valid toggles 50% -> mat_index increments only on accepted beats, never repeats, and mat_a/mat_b hold during gaps.
- Readback: model returns sumout=index*3 after RD_LAT=1; assert mat_done -> 32 results with res_idx 0..31 and data 0,3,...,93 in order; done pulses once.
- Backpressure: res_ready low for 20 cycles mid-READ -> no more than FIFO_DEPTH results buffered, no loss, order preserved.
- Reset mid-LOAD at beat 200 -> all outputs 0 next edge, busy=0; a fresh start restarts at index 1.
- Watchdog (macro defined, TIMEOUT=100): mat_done never asserted -> err=1 at cycle 100 of WAIT, IDLE, no done; next start clears err.

Source files
------------

// File: rtl/mat_pkg.sv
// -----------------------------------------------------------------------------
// mat_pkg
// Shared types and constants for the matrix-feed controller.
//   state_e       controller states
//   DATA_W_DEF    default operand/result width
//   NUM_ELEM_DEF  operand pairs per load
//   NUM_RES_DEF   result words read back
//   IDX_W         width of the pipeline index bus
//   RIDX_W        width of the result index tag
//   END_MARKER    index value that tells the pipeline the load is complete
// -----------------------------------------------------------------------------
package mat_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, READ, DRAIN} state_e;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_ELEM_DEF = 512;
  localparam int NUM_RES_DEF  = 32;
  localparam int IDX_W        = 32;
  localparam int RIDX_W       = 8;
  localparam int END_MARKER   = NUM_ELEM_DEF + 1;

  // End marker for an arbitrary element count (one past the last load index).
  function automatic logic [IDX_W-1:0] end_marker(input int num_elem);
    return IDX_W'(num_elem + 1);
  endfunction

endpackage

// File: rtl/mat_res_fifo.sv
// -----------------------------------------------------------------------------
// mat_res_fifo
// First-word-fall-through FIFO holding {result index, result data} words.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   push_i/wdata_i write side (a push while full is taken only with a pop)
//   pop_i          consume head word (ignored when empty)
//   rdata_o        head word, valid whenever empty_o is low
//   full_o, empty_o, count_o  occupancy status
// -----------------------------------------------------------------------------
module mat_res_fifo import mat_pkg::*; #(
  parameter int WIDTH = RIDX_W + DATA_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mat_feed_ctrl.sv
// -----------------------------------------------------------------------------
// mat_feed_ctrl
// Writer side of the matrix pipeline: streams operand pairs in as a 1-based
// indexed load, sends the end marker, waits for mat_done_i, then sweeps the
// result index and returns results through a FWFT buffer.
// Optional watchdog on the wait for mat_done_i: macro MAT_FEED_TIMEOUT_EN.
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   start_i                           start a job (IDLE only)
//   in_valid_i/in_ready_o/in_a_i/in_b_i   operand pair stream
//   mat_a_o/mat_b_o/mat_index_o       load/readback drive to the pipeline
//   mat_done_i/mat_sumout_i           pipeline completion flag and result
//   res_valid_o/res_ready_i/res_data_o/res_idx_o  result stream
//   busy_o, done_o, err_o             status
//
// state | meaning
// IDLE  | mat_index 0, waiting for start
// LOAD  | accepting operand beats; end marker driven once all are in
// WAIT  | holding end marker until the pipeline reports completion
// READ  | issuing result indices under buffer credit
// DRAIN | waiting for outstanding captures and the final pop
// -----------------------------------------------------------------------------
module mat_feed_ctrl import mat_pkg::*; #(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int NUM_ELEM   = NUM_ELEM_DEF,
  parameter int NUM_RES    = NUM_RES_DEF,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 65535
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic signed [DATA_W-1:0] in_a_i,
  input  logic signed [DATA_W-1:0] in_b_i,
  output logic signed [DATA_W-1:0] mat_a_o,
  output logic signed [DATA_W-1:0] mat_b_o,
  output logic [IDX_W-1:0]         mat_index_o,
  input  logic                     mat_done_i,
  input  logic signed [DATA_W-1:0] mat_sumout_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic signed [DATA_W-1:0] res_data_o,
  output logic [RIDX_W-1:0]        res_idx_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  localparam int FW = RIDX_W + DATA_W;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = CW + 1;
  localparam int PL = RD_LAT + 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_ELEM);
  localparam logic [IDX_W-1:0]  END_IDX   = end_marker(NUM_ELEM);
  localparam logic [RIDX_W-1:0] LAST_RIDX = RIDX_W'(NUM_RES - 1);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        mat_index_q, mat_index_d;
  logic signed [DATA_W-1:0] mat_a_q, mat_a_d, mat_b_q, mat_b_d;
  logic [RIDX_W-1:0]       ridx_q, ridx_d;
  logic [PL-1:0]           pv_q;
  logic [RIDX_W-1:0]       ptag_q [PL];
  logic                    issue, load_rdy;
  logic [SW-1:0]           inflight;
  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]           fifo_count;
  logic [FW-1:0]           fifo_rdata;

`ifdef MAT_FEED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
  assign err_o = err_q;
`else
  // No error source without the watchdog; TIMEOUT is a non-negative count.
  assign err_o = (TIMEOUT < 0);
`endif

  assign mat_a_o     = mat_a_q;
  assign mat_b_o     = mat_b_q;
  assign mat_index_o = mat_index_q;
  assign busy_o      = (state_q != IDLE);

  // Indices issued whose results have not yet landed in the buffer.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < PL; i++) inflight = inflight + SW'(pv_q[i]);
  end

  assign fifo_push   = pv_q[PL-1];
  assign fifo_pop    = res_ready_i && !fifo_empty;
  assign res_valid_o = !fifo_empty;
  assign res_idx_o   = fifo_rdata[FW-1 -: RIDX_W];
  assign res_data_o  = fifo_rdata[DATA_W-1:0];
  assign done_o      = (state_q == DRAIN) && fifo_pop && (inflight == '0) &&
                       (fifo_count == CW'(1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mat_index_d = mat_index_q;
    mat_a_d     = mat_a_q;
    mat_b_d     = mat_b_q;
    ridx_d      = ridx_q;
    load_rdy    = 1'b0;
    issue       = 1'b0;
`ifdef MAT_FEED_TIMEOUT_EN
    wd_d        = wd_q;
    err_d       = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = LOAD;
          cnt_d   = '0;
`ifdef MAT_FEED_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      LOAD: begin
        load_rdy = (cnt_q != LAST_IDX);
        if (load_rdy && in_valid_i) begin
          mat_a_d     = in_a_i;
          mat_b_d     = in_b_i;
          cnt_d       = cnt_q + 1'b1;
          mat_index_d = cnt_q + 1'b1;
        end else if (!load_rdy) begin
          mat_index_d = END_IDX;
          state_d     = WAIT;
`ifdef MAT_FEED_TIMEOUT_EN
          wd_d        = WD_W'(TIMEOUT - 1);
`endif
        end
      end
      WAIT: begin
        if (mat_done_i) begin
          ridx_d  = '0;
          state_d = READ;
        end
`ifdef MAT_FEED_TIMEOUT_EN
        else if (wd_q == '0) begin
          err_d       = 1'b1;
          mat_index_d = '0;
          state_d     = IDLE;
        end else begin
          wd_d = wd_q - 1'b1;
        end
`endif
      end
      READ: begin
        // Credit check is conservative: a pop this cycle is not counted.
        issue = ((inflight + SW'(fifo_count)) < SW'(FIFO_DEPTH));
        if (issue) begin
          mat_index_d = IDX_W'(ridx_q);
          ridx_d      = ridx_q + 1'b1;
          if (ridx_q == LAST_RIDX) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (done_o) begin
          mat_index_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready_o = load_rdy;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mat_index_q <= '0;
      mat_a_q     <= '0;
      mat_b_q     <= '0;
      ridx_q      <= '0;
      pv_q        <= '0;
      for (int i = 0; i < PL; i++) ptag_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mat_index_q <= mat_index_d;
      mat_a_q     <= mat_a_d;
      mat_b_q     <= mat_b_d;
      ridx_q      <= ridx_d;
      // Stage k holds an index presented k+1 cycles ago; the last stage
      // lines up with mat_sumout_i becoming valid.
      pv_q[0]     <= issue;
      ptag_q[0]   <= ridx_q;
      for (int i = 1; i < PL; i++) begin
        pv_q[i]   <= pv_q[i-1];
        ptag_q[i] <= ptag_q[i-1];
      end
    end
  end

`ifdef MAT_FEED_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
`endif

  mat_res_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .wdata_i ({ptag_q[PL-1], mat_sumout_i}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_mat_feed_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mat_feed_ctrl
// Self-checking bench: a phase-level model of the load/readback job predicts
// every output each cycle; a small pipeline responder returns index*3 one
// cycle after each index. Build with MAT_FEED_TIMEOUT_EN to add the watchdog
// scenario.
// -----------------------------------------------------------------------------
module tb_mat_feed_ctrl;

  localparam int DATA_W     = 32;
  localparam int NUM_ELEM   = 512;
  localparam int NUM_RES    = 32;
  localparam int RD_LAT     = 1;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 100;
  localparam int BUDGET     = 20000;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic mat_done = 1'b0, res_ready = 1'b0;
  logic signed [DATA_W-1:0] in_a = '0, in_b = '0, mat_sumout = '0;
  logic in_ready, res_valid, busy, done, err;
  logic signed [DATA_W-1:0] mat_a, mat_b, res_data;
  logic [31:0] mat_index;
  logic [7:0]  res_idx;

  always #5 clk = ~clk;

  mat_feed_ctrl #(
    .DATA_W(DATA_W), .NUM_ELEM(NUM_ELEM), .NUM_RES(NUM_RES),
    .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_a_i(in_a), .in_b_i(in_b),
    .mat_a_o(mat_a), .mat_b_o(mat_b), .mat_index_o(mat_index),
    .mat_done_i(mat_done), .mat_sumout_i(mat_sumout),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
    .res_idx_o(res_idx), .busy_o(busy), .done_o(done), .err_o(err)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Pipeline responder: result for an index appears one cycle after it.
  logic [31:0] prev_idx = '0;
  initial forever begin
    @(posedge clk); #1;
    mat_sumout = DATA_W'(prev_idx * 3);
    prev_idx   = mat_index;
  end

  // Job-phase model: 0 idle, 1 loading, 2 waiting on completion, 3 readback.
  int m_ph = 0, m_acc = 0, m_wcyc = 0, m_rdcyc = 0, m_popped = 0, n_done = 0;
  logic [31:0] m_idx = '0;
  logic signed [DATA_W-1:0] m_a = '0, m_b = '0;
  bit m_err = 1'b0;
  logic signed [DATA_W-1:0] res_log [NUM_RES];

  always @(negedge clk) begin
    bit pop, fin;
    if (rst) begin
      m_ph = 0; m_acc = 0; m_idx = '0; m_a = '0; m_b = '0; m_err = 1'b0; m_popped = 0;
      chk("rst_mat_index", mat_index, 0);
      chk("rst_mat_a", mat_a, 0);
      chk("rst_mat_b", mat_b, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_res_idx", res_idx, 0);
    end else begin
      pop = res_valid && res_ready;
      chk("busy", busy, m_ph != 0);
      chk("in_ready", in_ready, (m_ph == 1) && (m_acc < NUM_ELEM));
      chk("err", err, m_err);
      if (m_ph <= 2) begin
        chk("mat_index", mat_index, m_idx);
        chk("mat_a", mat_a, m_a);
        chk("mat_b", mat_b, m_b);
        chk("res_valid_quiet", res_valid, 0);
      end
      fin = (m_ph == 3) && pop && (m_popped == NUM_RES - 1);
      chk("done", done, fin);
      if (done) n_done++;
      if (m_ph == 3) begin
        if (m_popped == 0) chk("first_res_valid", res_valid, m_rdcyc >= RD_LAT + 2);
        if (pop) begin
          chk("res_idx", res_idx, m_popped);
          chk("res_data", res_data, m_popped * 3);
          res_log[m_popped] = res_data;
        end
        chk("fifo_overflow", dut.fifo_push && dut.fifo_full && !dut.fifo_pop, 0);
      end
      // Advance the model across the coming clock edge.
      case (m_ph)
        0: if (start) begin m_ph = 1; m_acc = 0; m_err = 1'b0; end
        1: begin
          if (m_acc < NUM_ELEM) begin
            if (in_valid) begin m_acc++; m_idx = m_acc; m_a = in_a; m_b = in_b; end
          end else begin
            m_idx = NUM_ELEM + 1; m_ph = 2; m_wcyc = 0;
          end
        end
        2: begin
          if (mat_done) begin m_ph = 3; m_rdcyc = 0; m_popped = 0; end
`ifdef MAT_FEED_TIMEOUT_EN
          else begin
            m_wcyc++;
            if (m_wcyc == TIMEOUT) begin m_ph = 0; m_err = 1'b1; m_idx = '0; end
          end
`endif
        end
        3: begin
          m_rdcyc++;
          if (pop) begin
            m_popped++;
            if (m_popped == NUM_RES) begin m_ph = 0; m_idx = '0; end
          end
        end
        default: m_ph = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  int cur_beat = -1;
  task automatic drive_beat(input int vpct, input bit rnd);
    in_valid = ($urandom_range(99) < vpct);
    if (m_acc != cur_beat) begin
      cur_beat = m_acc;
      if (rnd) begin in_a = $urandom; in_b = $urandom; end
      else begin in_a = m_acc + 1; in_b = -(m_acc + 1); end
    end
  endtask

  // vpct: in_valid probability; bp_at: pop count at which res_ready is held
  // low for 20 cycles (-1 = random ready); drop: release mat_done mid-READ.
  task automatic run_job(input int vpct, input bit rnd, input int bp_at, input bit drop);
    int budget, d0, bp_left;
    d0 = n_done;
    start = 1'b1; tick(); start = 1'b0;
    budget = 0;
    while (m_ph == 1 && budget < BUDGET) begin drive_beat(vpct, rnd); tick(); budget++; end
    in_valid = 1'b0;
    chk("load_budget", budget < BUDGET, 1);
    chk("end_marker", mat_index, 513);
    chk("in_ready_after_last", in_ready, 0);
    repeat ($urandom_range(6)) tick();
    mat_done = 1'b1;
    budget = 0; bp_left = 0;
    while (m_ph != 0 && budget < BUDGET) begin
      if (drop && m_ph == 3 && m_rdcyc == 3) mat_done = 1'b0;
      if (bp_at >= 0) begin
        if (m_popped == bp_at && bp_left == 0 && budget < 1000) begin bp_left = 20; bp_at = -2; end
        if (bp_left > 0) begin res_ready = 1'b0; bp_left--; end
        else res_ready = 1'b1;
      end else begin
        res_ready = ($urandom_range(99) < 70);
      end
      tick(); budget++;
    end
    chk("read_budget", budget < BUDGET, 1);
    mat_done = 1'b0; res_ready = 1'b0;
    chk("done_pulses", n_done - d0, 1);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Streaming load, a=i b=-i, no gaps.
    run_job(100, 1'b0, -1, 1'b0);
    chk("lit_res0", res_log[0], 0);
    chk("lit_res1", res_log[1], 3);
    chk("lit_res31", res_log[31], 93);

    // Bubbles with random data, completion flag dropped during the sweep.
    run_job(50, 1'b1, -1, 1'b1);
    // Result backpressure mid-sweep.
    run_job(80, 1'b1, 5, 1'b0);

    // Reset in the middle of a load.
    start = 1'b1; tick(); start = 1'b0;
    while (m_ph == 1 && m_acc < 200) begin drive_beat(100, 1'b0); tick(); end
    in_valid = 1'b0;
    chk("idx_at_200", mat_index, 200);
    rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
    chk("busy_after_rst", busy, 0);
    run_job(100, 1'b0, -1, 1'b0);

`ifdef MAT_FEED_TIMEOUT_EN
    begin
      int d0, budget;
      d0 = n_done;
      start = 1'b1; tick(); start = 1'b0;
      budget = 0;
      while (m_ph == 1 && budget < BUDGET) begin drive_beat(100, 1'b1); tick(); budget++; end
      in_valid = 1'b0;
      while (m_ph != 0 && budget < BUDGET) begin tick(); budget++; end
      chk("wd_budget", budget < BUDGET, 1);
      tick();
      chk("wd_err", err, 1);
      chk("wd_busy", busy, 0);
      chk("wd_no_done", n_done - d0, 0);
      run_job(60, 1'b1, -1, 1'b0);
      chk("wd_err_cleared", err, 0);
    end
`endif

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
